// File: rtl/key_streamer_pkg.sv
// key_streamer_pkg: shared definitions for the key memory subsystem.
// Holds the key-streamer state encoding, default key length and ROM
// address width, word/byte widths, and small state classification helpers.
package key_streamer_pkg;

  // Default number of 16-bit key words streamed per request.
  localparam int unsigned KS_KEY_WORDS_DFLT = 10;
  // Default MSB of the key ROM word address bus.
  localparam int unsigned KS_ADDR_MSB_DFLT  = 4;

  localparam int unsigned KS_WORD_W = 16;
  localparam int unsigned KS_BYTE_W = 8;

  typedef enum logic [2:0] {
    KS_IDLE    = 3'd0,
    KS_REQ     = 3'd1,
    KS_CAPT    = 3'd2,
    KS_SEND_HI = 3'd3,
    KS_SEND_LO = 3'd4,
    KS_DONE    = 3'd5
  } ks_state_e;

  // States in which a byte is presented to the consumer.
  function automatic logic ks_is_send(input ks_state_e s);
    return (s == KS_SEND_HI) || (s == KS_SEND_LO);
  endfunction

  // States in which dropping key_en terminates the transfer.
  function automatic logic ks_is_abortable(input ks_state_e s);
    return (s == KS_REQ) || (s == KS_CAPT) || ks_is_send(s);
  endfunction

endpackage

// File: rtl/key_streamer.sv
// key_streamer: on a start request, reads KEY_WORDS 16-bit words from the
// key ROM and streams them as bytes (high byte first) over a valid/ready
// interface. Dropping key_en mid-transfer aborts the stream.
//
// Ports:
//   mclk, puc_rst         clock, synchronous active-high reset
//   start, key_en         stream request, key access permission
//   rom_addr/rom_cen/rom_dout  key ROM word address, active-low enable, data
//   kout_data/kout_valid/kout_ready/kout_last  byte stream to consumer
//   busy, done, abort     status: not idle, stream complete, stream aborted
module key_streamer
  import key_streamer_pkg::*;
#(
  parameter int unsigned KEY_WORDS = KS_KEY_WORDS_DFLT,
  parameter int unsigned ADDR_MSB  = KS_ADDR_MSB_DFLT
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  input  logic                 start,
  input  logic                 key_en,
  output logic [ADDR_MSB:0]    rom_addr,
  output logic                 rom_cen,
  input  logic [KS_WORD_W-1:0] rom_dout,
  output logic [KS_BYTE_W-1:0] kout_data,
  output logic                 kout_valid,
  input  logic                 kout_ready,
  output logic                 kout_last,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  localparam int unsigned IDX_W = ADDR_MSB + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_WORDS - 1);

  ks_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [KS_WORD_W-1:0] word_q, word_d;

  logic [IDX_W-1:0]     rom_addr_q, rom_addr_d;
  logic                 rom_cen_q, rom_cen_d;
  logic [KS_BYTE_W-1:0] kout_data_q, kout_data_d;
  logic                 kout_valid_q, kout_valid_d;
  logic                 kout_last_q, kout_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;

  // Next state, word index and captured word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    abort_d = 1'b0;

    case (state_q)
      KS_IDLE: begin
        if (start && key_en) begin
          state_d = KS_REQ;
          idx_d   = '0;
        end
      end
      KS_REQ: begin
        state_d = KS_CAPT;
      end
      KS_CAPT: begin
        word_d  = rom_dout;
        state_d = KS_SEND_HI;
      end
      KS_SEND_HI: begin
        if (kout_ready) begin
          state_d = KS_SEND_LO;
        end
      end
      KS_SEND_LO: begin
        if (kout_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = KS_DONE;
            word_d  = '0;
          end else begin
            state_d = KS_REQ;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      KS_DONE: begin
        state_d = KS_IDLE;
        idx_d   = '0;
        word_d  = '0;
      end
      default: begin
        state_d = KS_IDLE;
        idx_d   = '0;
        word_d  = '0;
      end
    endcase

    // Losing key access overrides any handshake; the presented byte is dropped.
    if (ks_is_abortable(state_q) && !key_en) begin
      state_d = KS_IDLE;
      idx_d   = '0;
      word_d  = '0;
      abort_d = 1'b1;
    end
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin
    rom_cen_d    = (state_d != KS_REQ);
    rom_addr_d   = (state_d == KS_IDLE) ? '0 : idx_d;
    kout_valid_d = ks_is_send(state_d);
    kout_last_d  = (state_d == KS_SEND_LO) && (idx_d == IDX_LAST);
    busy_d       = (state_d != KS_IDLE);
    done_d       = (state_d == KS_DONE);

    case (state_d)
      KS_SEND_HI: kout_data_d = word_d[KS_WORD_W-1:KS_BYTE_W];
      KS_SEND_LO: kout_data_d = word_d[KS_BYTE_W-1:0];
      default:    kout_data_d = '0;
    endcase
  end

  // State and registered outputs; reset wins over every input.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q      <= KS_IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      rom_addr_q   <= '0;
      rom_cen_q    <= 1'b1;
      kout_data_q  <= '0;
      kout_valid_q <= 1'b0;
      kout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      rom_addr_q   <= rom_addr_d;
      rom_cen_q    <= rom_cen_d;
      kout_data_q  <= kout_data_d;
      kout_valid_q <= kout_valid_d;
      kout_last_q  <= kout_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_cen    = rom_cen_q;
  assign kout_data  = kout_data_q;
  assign kout_valid = kout_valid_q;
  assign kout_last  = kout_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_key_streamer.sv
// tb_key_streamer: self-checking bench for key_streamer. A behavioural ROM
// and an expected byte stream derived from the ROM contents are kept here;
// stimulus is driven after each falling edge and outputs sampled there.
module tb_key_streamer;

  localparam int KW  = 10;
  localparam int AM  = 4;
  localparam int AW  = AM + 1;
  localparam int NB  = 2 * KW;
  localparam int MEM = 1 << AW;

  logic          mclk = 1'b0;
  logic          puc_rst;
  logic          start;
  logic          key_en;
  logic          kout_ready;
  logic [AM:0]   rom_addr;
  logic          rom_cen;
  logic [15:0]   rom_dout = 16'h0000;
  logic [7:0]    kout_data;
  logic          kout_valid;
  logic          kout_last;
  logic          busy;
  logic          done;
  logic          abort;

  logic [15:0]   mem [0:MEM-1];

  int vec_cnt = 0;
  int err_cnt = 0;

  key_streamer #(.KEY_WORDS(KW), .ADDR_MSB(AM)) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .start      (start),
    .key_en     (key_en),
    .rom_addr   (rom_addr),
    .rom_cen    (rom_cen),
    .rom_dout   (rom_dout),
    .kout_data  (kout_data),
    .kout_valid (kout_valid),
    .kout_ready (kout_ready),
    .kout_last  (kout_last),
    .busy       (busy),
    .done       (done),
    .abort      (abort)
  );

  always #5 mclk = ~mclk;

  // Synchronous key ROM: data appears the cycle after an enabled address edge.
  always @(posedge mclk) begin
    if (rom_cen === 1'b0) rom_dout <= mem[rom_addr];
  end

  task automatic tick();
    @(negedge mclk);
  endtask

  // Byte b of the key: even bytes are word high halves, odd bytes low halves.
  function automatic logic [7:0] exp_byte(input int b);
    logic [15:0] w;
    w = mem[b / 2];
    return (b % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic load_known();
    for (int i = 0; i < MEM; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0123;
    mem[1] = 16'h4567;
    mem[2] = 16'h89ab;
    mem[3] = 16'hcdef;
  endtask

  task automatic load_random();
    for (int i = 0; i < MEM; i++) mem[i] = 16'($urandom);
  endtask

  // Runs one full stream from a start pulse; ready is random with ready_pct
  // probability, optionally stalled 5 cycles on byte stall_byte, and a stray
  // start pulse is injected at cycle restart_cyc (ignored by the DUT).
  task automatic drive_stream(input int ready_pct, input int stall_byte, input int restart_cyc);
    int          nb;
    int          cyc;
    int          stall_left;
    bit          fin;
    bit          prev_hold;
    bit          accepted_prev;
    bit          full;
    bit          rdy;
    logic [7:0]  prev_data;
    nb = 0; cyc = 0; stall_left = 5; fin = 0; prev_hold = 0; accepted_prev = 0;
    prev_data = 8'h00;
    full = (ready_pct >= 100) && (stall_byte < 0);
    key_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (prev_hold) begin
        vec_cnt++;
        if (kout_valid !== 1'b1 || kout_data !== prev_data) begin
          err_cnt++;
          $display("FAIL hold cyc=%0d: valid=%b data=%h, required valid=1 data=%h", cyc, kout_valid, kout_data, prev_data);
        end
      end
      if (kout_valid !== 1'b1) begin
        vec_cnt++;
        if (kout_data !== 8'h00 || kout_last !== 1'b0) begin
          err_cnt++;
          $display("FAIL idle_data cyc=%0d: data=%h last=%b, required 00/0", cyc, kout_data, kout_last);
        end
      end
      vec_cnt++;
      if (abort !== 1'b0 || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL status cyc=%0d: abort=%b busy=%b, required 0/1", cyc, abort, busy);
      end
      if (rom_cen === 1'b0) begin
        vec_cnt++;
        if (rom_addr !== AW'(nb / 2)) begin
          err_cnt++;
          $display("FAIL rom_addr cyc=%0d: got %0d, required %0d", cyc, rom_addr, nb / 2);
        end
      end
      if (accepted_prev && nb == NB) begin
        vec_cnt++;
        if (done !== 1'b1) begin
          err_cnt++;
          $display("FAIL done_pulse cyc=%0d: done=%b, required 1", cyc, done);
        end
        if (full) begin
          vec_cnt++;
          if (cyc != 4 * KW + 1) begin
            err_cnt++;
            $display("FAIL done_cycle: got %0d, required %0d", cyc, 4 * KW + 1);
          end
        end
        fin = 1;
      end else begin
        vec_cnt++;
        if (done !== 1'b0) begin
          err_cnt++;
          $display("FAIL early_done cyc=%0d: done=%b nb=%0d, required 0", cyc, done, nb);
        end
      end
      if (!fin) begin
        if (kout_valid === 1'b1 && nb == stall_byte && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (kout_valid === 1'b1 && nb == stall_byte) begin
          rdy = 1'b1;
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
        end
        kout_ready = rdy;
        accepted_prev = 0;
        prev_hold = 0;
        if (kout_valid === 1'b1) begin
          if (rdy) begin
            vec_cnt++;
            if (kout_data !== exp_byte(nb)) begin
              err_cnt++;
              $display("FAIL byte[%0d]: got %h, required %h", nb, kout_data, exp_byte(nb));
            end
            vec_cnt++;
            if (kout_last !== (nb == NB - 1)) begin
              err_cnt++;
              $display("FAIL last[%0d]: got %b, required %b", nb, kout_last, (nb == NB - 1));
            end
            if (full) begin
              vec_cnt++;
              if (cyc != 3 + 4 * (nb / 2) + (nb % 2)) begin
                err_cnt++;
                $display("FAIL rate[%0d]: cycle %0d, required %0d", nb, cyc, 3 + 4 * (nb / 2) + (nb % 2));
              end
            end
            nb++;
            accepted_prev = 1;
          end else begin
            prev_hold = 1;
            prev_data = kout_data;
          end
        end
        start = (cyc == restart_cyc);
        tick();
      end
    end
    start = 1'b0;
    kout_ready = 1'b0;
    if (!fin) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL stream_timeout: %0d bytes after %0d cycles, required %0d bytes then done", nb, cyc, NB);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || rom_cen !== 1'b1 || kout_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL post_idle[%0d]: busy=%b done=%b cen=%b valid=%b, required 0/0/1/0", i, busy, done, rom_cen, kout_valid);
      end
    end
  endtask

  task automatic test_reset();
    puc_rst = 1'b1; start = 1'b0; key_en = 1'b1; kout_ready = 1'b0;
    tick(); tick();
    vec_cnt++;
    if ({rom_cen, rom_addr, kout_valid, kout_data, kout_last, busy, done, abort} !== {1'b1, 18'd0}) begin
      err_cnt++;
      $display("FAIL reset_vals: got %h, required %h",
               {rom_cen, rom_addr, kout_valid, kout_data, kout_last, busy, done, abort}, {1'b1, 18'd0});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vec_cnt++;
    if (busy !== 1'b0 || rom_cen !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_priority: busy=%b cen=%b, required 0/1", busy, rom_cen);
    end
    puc_rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    load_known();
    kout_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++;
    if (rom_cen !== 1'b0 || rom_addr !== AW'(0) || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL lat_n1: cen=%b addr=%0d busy=%b, required 0/0/1", rom_cen, rom_addr, busy);
    end
    tick();
    vec_cnt++;
    if (rom_cen !== 1'b1 || kout_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL lat_n2: cen=%b valid=%b, required 1/0", rom_cen, kout_valid);
    end
    tick();
    vec_cnt++;
    if (kout_valid !== 1'b1 || kout_data !== 8'h01) begin
      err_cnt++;
      $display("FAIL lat_n3: valid=%b data=%h, required 1/01", kout_valid, kout_data);
    end
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    load_known();
    drive_stream(100, -1, -1);
  endtask

  task automatic test_backpressure();
    load_known();
    drive_stream(100, 2, -1);
  endtask

  task automatic test_abort();
    int nb;
    bit hit;
    load_known();
    key_en = 1'b1; kout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (kout_valid === 1'b1) begin
        if (nb == 5) hit = 1;
        else nb++;
      end
      if (!hit) tick();
    end
    vec_cnt++;
    if (!hit || kout_data !== 8'hab || kout_last !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_setup: reached=%b data=%h last=%b, required 1/ab/0", hit, kout_data, kout_last);
    end
    key_en = 1'b0;
    tick();
    vec_cnt++;
    if (abort !== 1'b1 || kout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || kout_data !== 8'h00 || rom_cen !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_next: abort=%b valid=%b busy=%b done=%b data=%h cen=%b, required 1/0/0/0/00/1",
               abort, kout_valid, busy, done, kout_data, rom_cen);
    end
    key_en = 1'b1;
    kout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (abort !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL abort_after[%0d]: abort=%b done=%b busy=%b, required 0/0/0", i, abort, done, busy);
      end
    end
    drive_stream(100, -1, -1);
  endtask

  task automatic test_ignore();
    load_known();
    key_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rom_cen !== 1'b1 || busy !== 1'b0 || kout_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL ignore_noen[%0d]: cen=%b busy=%b valid=%b, required 1/0/0", i, rom_cen, busy, kout_valid);
      end
      tick();
    end
    key_en = 1'b1;
    drive_stream(100, -1, 9);
    load_random();
    drive_stream(70, -1, 6);
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_random();
    key_en = 1'b1; kout_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (kout_valid === 1'b1) seen = 1;
      else tick();
    end
    vec_cnt++;
    if (!seen || kout_data !== exp_byte(0)) begin
      err_cnt++;
      $display("FAIL rstmid_setup: reached=%b data=%h, required 1/%h", seen, kout_data, exp_byte(0));
    end
    puc_rst = 1'b1; key_en = 1'b0; start = 1'b1; kout_ready = 1'b1;
    tick();
    vec_cnt++;
    if ({rom_cen, rom_addr, kout_valid, kout_data, kout_last, busy, done, abort} !== {1'b1, 18'd0}) begin
      err_cnt++;
      $display("FAIL rstmid_vals: got %h, required %h",
               {rom_cen, rom_addr, kout_valid, kout_data, kout_last, busy, done, abort}, {1'b1, 18'd0});
    end
    puc_rst = 1'b0; key_en = 1'b1; start = 1'b0; kout_ready = 1'b0;
    tick();
    vec_cnt++;
    if (abort !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstmid_after: abort=%b done=%b busy=%b, required 0/0/0", abort, done, busy);
    end
    drive_stream(100, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      load_random();
      drive_stream(int'($urandom_range(100, 30)),
                   ($urandom_range(1) == 1) ? int'($urandom_range(NB - 1)) : -1,
                   int'($urandom_range(40, 2)));
    end
  endtask

  initial begin
    puc_rst = 1'b1; start = 1'b0; key_en = 1'b1; kout_ready = 1'b0;
    for (int i = 0; i < MEM; i++) mem[i] = 16'h0000;
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_abort();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
